apb_master_nslv: RTL and testbench

Parametrised APB master bridge, the next generation of the team's 2-slave APB master. It accepts single read/write commands on a valid/ready host interface and drives an APB bus with NUM_SLV one-hot PSEL lines. Adds over the previous block: configurable address/data widths, byte strobes, per-slave ready/error muxing, decode-error reporting, and an optional access timeout.

---
 rtl/apb_master_nslv.sv | 204 ++++++++++++++++++++
 tb/tb_apb_master_nslv.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_nslv.sv
// ---------------------------------------------------------------------------
// apb_master_nslv -- single-command APB master bridge driving NUM_SLV slaves.
//
// Accepts one read/write command at a time on a valid/ready host interface,
// decodes the slave index from cmd_addr[SEL_LSB +: SEL_W], runs one APB
// SETUP/ACCESS transfer on the selected one-hot PSEL line, and returns a
// one-cycle rsp_valid pulse carrying read data and an error flag.
// Indices that do not map to an existing slave complete immediately with
// rsp_err=1 and no bus activity.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN): aborts an ACCESS phase that
// has waited TIMEOUT cycles without PREADY, answering with rsp_err=1.
//
// Ports:
//   PCLK, PRESETn           clock; synchronous active-high reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_write/addr/wdata/strb  command fields
//   rsp_valid/rdata/err     completion pulse, read data, error flag
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB  APB request outputs
//   PRDATA/PREADY/PSLVERR   per-slave APB responses (slave i in slice i)
// ---------------------------------------------------------------------------
module apb_master_nslv #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_wdata,
  input  logic [DATA_W/8-1:0]         cmd_strb,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_SLV-1:0]          PSEL,
  output logic                        PENABLE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W/8-1:0]         PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV-1:0]          PSLVERR
);

  localparam int unsigned SEL_W  = (NUM_SLV > 2) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [SEL_W:0] NumSlvW = (SEL_W + 1)'(NUM_SLV);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [SEL_W-1:0]    cmd_idx;
  logic                decode_err;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLV-1:0]  sel_onehot;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign cmd_idx    = cmd_addr[SEL_LSB +: SEL_W];
  assign decode_err = ({1'b0, cmd_idx} >= NumSlvW);

  // Select the addressed slave's response lines; all others are ignored.
  always_comb begin
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ready     = PREADY[i];
        sel_err       = PSLVERR[i];
        sel_rdata     = PRDATA[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          idx_d = cmd_idx;
          if (decode_err) begin
            // Response fields are latched now so they are visible in StErr.
            state_d     = StErr;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = StSetup;
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_write ? cmd_strb : '0;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StAccess: begin
        // A PREADY on the limit edge still completes normally.
        if (sel_ready) begin
          state_d     = StResp;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
          rsp_err_d   = sel_err;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (cnt_q == CntLimit) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    PENABLE   = (state_q == StAccess);
    PSEL      = ((state_q == StSetup) || (state_q == StAccess)) ? sel_onehot : '0;
    rsp_valid = (state_q == StResp) || (state_q == StErr);
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    PSTRB     = pstrb_q;
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// ---------------------------------------------------------------------------
// tb_apb_master_nslv -- directed self-checking bench for apb_master_nslv.
// Main instance: 4 slaves. Second instance: 3 slaves, for decode errors.
// Expected responses are queued when a command is issued and popped when
// rsp_valid is seen. Behaviour of the timeout check follows
// APB_MASTER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_apb_master_nslv;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic         PCLK;
  logic         PRESETn;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_strb;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic         cmd_valid3, cmd_ready3, rsp_valid3, rsp_err3, penable3, pwrite3;
  logic [31:0]  rsp_rdata3, paddr3, pwdata3;
  logic [3:0]   pstrb3;
  logic [2:0]   psel3, pready3, pslverr3;
  logic [95:0]  prdata3;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  apb_master_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SEL_LSB(8), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SEL_LSB(8), .TIMEOUT(16)
  ) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .PSEL(psel3), .PENABLE(penable3), .PADDR(paddr3), .PWRITE(pwrite3),
    .PWDATA(pwdata3), .PSTRB(pstrb3),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
  endtask

  // Waits for rsp_valid; cycles are counted from the accept edge.
  task automatic wait_rsp(input string tag, input int exp_lat, input int start);
    int   cyc;
    rsp_t e;
    cyc = start;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (rsp_valid === 1'b1) begin
      chk({tag, "_lat"}, cyc, exp_lat);
      chk({tag, "_psel_rsp"}, {PSEL, PENABLE}, 5'b0);
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, rsp_err, e.err);
      end
    end else begin
      chk({tag, "_no_rsp"}, 0, 1);
    end
  endtask

  initial begin
    int seen;
    PRESETn    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    PRDATA     = '0;
    PREADY     = '0;
    PSLVERR    = '0;
    prdata3    = '0;
    pready3    = 3'b111;
    pslverr3   = '0;
    repeat (3) tick();
    PRESETn = 1'b0;
    tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_psel", PSEL, 4'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_rdata, rsp_err}, 33'h0);
    chk("rst_bus", {PADDR, PWRITE, PWDATA, PSTRB}, 69'h0);

    // 1: zero-wait write to slave 1
    PREADY = 4'b0010;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF);
    chk("t1_setup_psel", {PSEL, PENABLE, cmd_ready}, {4'b0010, 1'b0, 1'b0});
    chk("t1_setup_paddr", PADDR, 32'h0000_0104);
    chk("t1_setup_pwdata", {PWRITE, PWDATA, PSTRB}, {1'b1, 32'hDEAD_BEEF, 4'hF});
    tick();
    chk("t1_access_psel", {PSEL, PENABLE}, {4'b0010, 1'b1});
    chk("t1_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    wait_rsp("t1", 3, 2);
    tick();
    chk("t1_after", {rsp_valid, cmd_ready, PSEL}, {1'b0, 1'b1, 4'b0});

    // 2: read slave 3 with 3 wait states; unselected slave 0 is ready throughout
    PREADY = 4'b0001;
    PRDATA = {32'h1234_5678, 32'hFFFF_0002, 32'hFFFF_0001, 32'hFFFF_0000};
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    issue(1'b0, 32'h0000_0300, 32'hCAFE_0000, 4'hF);
    chk("t2_setup", {PSEL, PENABLE, PWRITE, PSTRB}, {4'b1000, 1'b0, 1'b0, 4'h0});
    chk("t2_paddr", PADDR, 32'h0000_0300);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait", {PSEL, PENABLE, PSTRB, rsp_valid}, {4'b1000, 1'b1, 4'h0, 1'b0});
      tick();
    end
    PREADY = 4'b1001;
    chk("t2_last_access", {PSEL, PENABLE, PSTRB}, {4'b1000, 1'b1, 4'h0});
    wait_rsp("t2", 6, 5);
    PREADY = 4'b0000;
    tick();
    chk("t2_hold", rsp_rdata, 32'h1234_5678);

    // 3: slave error on selected slave, then only on an unselected one
    PREADY  = 4'b0011;
    PSLVERR = 4'b0011;
    PRDATA  = {32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'h0000_0000};
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    chk("t3_psel", PSEL, 4'b0001);
    wait_rsp("t3a", 3, 1);
    tick();
    PSLVERR = 4'b0010;
    PRDATA  = {32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'hA5A5_0001};
    exp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b0});
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    wait_rsp("t3b", 3, 1);
    tick();
    PSLVERR = 4'b0000;

    // 4: 3-slave instance, valid read then decode error
    prdata3    = {32'h0BAD_F00D, 32'h0000_1111, 32'h0000_2222};
    cmd_write  = 1'b0;
    cmd_addr   = 32'h0000_0200;
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    chk("t4_psel_ok", psel3, 3'b100);
    tick();
    tick();
    chk("t4_rsp_ok", {rsp_valid3, rsp_err3, rsp_rdata3}, {1'b1, 1'b0, 32'h0BAD_F00D});
    tick();
    cmd_addr   = 32'h0000_0300;
    cmd_valid3 = 1'b1;
    tick();
    cmd_valid3 = 1'b0;
    chk("t4_decerr_rsp", {rsp_valid3, rsp_err3, rsp_rdata3}, {1'b1, 1'b1, 32'h0});
    chk("t4_decerr_bus", {psel3, penable3, cmd_ready3}, 5'b0);
    tick();
    chk("t4_after", {rsp_valid3, psel3, cmd_ready3, rsp_err3}, {1'b0, 3'b0, 1'b1, 1'b1});

    // 6: slave never ready
    PREADY = 4'b0000;
    PRDATA = {32'hFFFF_0003, 32'hFFFF_0002, 32'h7777_7777, 32'hFFFF_0000};
`ifdef APB_MASTER_TIMEOUT_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    wait_rsp("t6_timeout", 18, 1);
    tick();
    chk("t6_after", {cmd_ready, PSEL, PENABLE}, {1'b1, 4'b0, 1'b0});
`else
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    seen = 0;
    repeat (100) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    chk("t6_no_rsp", seen, 0);
    chk("t6_still_access", {PSEL, PENABLE}, {4'b0010, 1'b1});
    PRESETn = 1'b1;
    tick();
    PRESETn = 1'b0;
    chk("t6_recover", {cmd_ready, PSEL, PENABLE}, {1'b1, 4'b0, 1'b0});
`endif

    // 5: reset during ACCESS aborts silently
    PREADY = 4'b0000;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    chk("t5_in_access", {PSEL, PENABLE}, {4'b0100, 1'b1});
    PRESETn = 1'b1;
    tick();
    PRESETn = 1'b0;
    chk("t5_bus", {PSEL, PENABLE, cmd_ready, rsp_valid}, {4'b0, 1'b0, 1'b1, 1'b0});
    chk("t5_regs", {PADDR, rsp_rdata, rsp_err}, 65'h0);
    PREADY = 4'hF;
    seen = 0;
    repeat (3) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    chk("t5_no_rsp", seen, 0);

    // Normal write after reset, partial strobes
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(1'b1, 32'h0000_02FC, 32'h0102_0304, 4'h5);
    chk("t7_setup", {PSEL, PSTRB, PWDATA}, {4'b0100, 4'h5, 32'h0102_0304});
    wait_rsp("t7", 3, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
